// File: rtl/coffee_brew_sequencer_pkg.sv
// Shared types and constants for the coffee brew sequencer: FSM state
// encoding, fault codes, default cycle counts and the sensor-fault priority.
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAT,
        ST_BREW,
        ST_DRIP,
        ST_DONE,
        ST_FAULT
    } brew_state_t;

    localparam logic [1:0] FAULT_CUP    = 2'd0;
    localparam logic [1:0] FAULT_WATER  = 2'd1;
    localparam logic [1:0] FAULT_FILTER = 2'd2;
    localparam logic [1:0] FAULT_TEMP   = 2'd3;

    localparam int DEF_HEAT_TIMEOUT = 16;
    localparam int DEF_BREW_CYCLES  = 32;
    localparam int DEF_DRIP_CYCLES  = 8;
    localparam int DEF_CNT_W        = 8;

    // Missing cup outranks missing water, which outranks a missing filter.
    function automatic logic [1:0] sensor_fault_code(input logic cup_ok, input logic water_ok);
        if (!cup_ok)   return FAULT_CUP;
        if (!water_ok) return FAULT_WATER;
        return FAULT_FILTER;
    endfunction

endpackage

// File: rtl/coffee_brew_sequencer_if.sv
// Front-panel / sensor bundle of the brew sequencer. The optional cup_count
// signal exists only when COFFEE_CUP_COUNTER_EN is defined.
interface coffee_brew_sequencer_if;

    logic       start_valid;
    logic       start_ready;
    logic       abort;
    logic       clear_fault;
    logic       filter_ok;
    logic       water_ok;
    logic       temp_ok;
    logic       cup_ok;
    logic       heater_on;
    logic       pump_on;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
`ifdef COFFEE_CUP_COUNTER_EN
    logic [15:0] cup_count;
`endif

    modport master (
        output start_valid, abort, clear_fault, filter_ok, water_ok, temp_ok, cup_ok,
        input  start_ready, heater_on, pump_on, busy, done, fault, fault_code
`ifdef COFFEE_CUP_COUNTER_EN
       ,input  cup_count
`endif
    );

    modport slave (
        input  start_valid, abort, clear_fault, filter_ok, water_ok, temp_ok, cup_ok,
        output start_ready, heater_on, pump_on, busy, done, fault, fault_code
`ifdef COFFEE_CUP_COUNTER_EN
       ,output cup_count
`endif
    );

endinterface

// File: rtl/coffee_brew_sequencer_timer.sv
// Loadable down-counter shared by the timed brew phases. Loading N-1 makes
// o_expired rise in the N-th cycle after the load.
module brew_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/coffee_brew_sequencer.sv
// Heat -> brew -> drip sequencer with latched fault codes. Optional cup
// counter enabled by defining COFFEE_CUP_COUNTER_EN. Cycle parameters: 1..2^CNT_W-1.
module coffee_brew_sequencer
    import coffee_pkg::*;
#(
    parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
    parameter int BREW_CYCLES  = DEF_BREW_CYCLES,
    parameter int DRIP_CYCLES  = DEF_DRIP_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    coffee_brew_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] HEAT_LOAD = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BREW_LOAD = CNT_W'(BREW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIP_LOAD = CNT_W'(DRIP_CYCLES - 1);

    brew_state_t      r_state, w_next;
    logic [1:0]       r_fault_code, w_fault_code;
    logic [CNT_W-1:0] w_load_val;
    logic             w_load, w_timer_en, w_expired;
    logic             r_start_ready, r_heater_on, r_pump_on, r_busy, r_done, r_fault;

    brew_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_timer_en),
        .o_expired  (w_expired)
    );

    // Fault checks precede abort in every active state so a simultaneous fault wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        w_next       = r_state;
        w_fault_code = r_fault_code;
        w_load_val   = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    if (bus.cup_ok && bus.water_ok && bus.filter_ok) begin
                        w_next = ST_HEAT;
                    end else begin
                        w_next       = ST_FAULT;
                        w_fault_code = sensor_fault_code(bus.cup_ok, bus.water_ok);
                    end
                end
            end
            ST_HEAT: begin
                if (w_expired && !bus.temp_ok) begin
                    w_next       = ST_FAULT;
                    w_fault_code = FAULT_TEMP;
                end else if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (bus.temp_ok) begin
                    w_next = ST_BREW;
                end
            end
            ST_BREW: begin
                if (!bus.cup_ok || !bus.water_ok) begin
                    w_next       = ST_FAULT;
                    w_fault_code = sensor_fault_code(bus.cup_ok, bus.water_ok);
                end else if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_next = ST_DRIP;
                end
            end
            ST_DRIP: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    w_next       = ST_IDLE;
                    w_fault_code = FAULT_CUP;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        case (w_next)
            ST_HEAT: w_load_val = HEAT_LOAD;
            ST_BREW: w_load_val = BREW_LOAD;
            ST_DRIP: w_load_val = DRIP_LOAD;
            default: w_load_val = '0;
        endcase
    end

    assign w_load     = (w_next != r_state);
    assign w_timer_en = (r_state == ST_HEAT) || (r_state == ST_BREW) || (r_state == ST_DRIP);

    // Outputs are decoded from the next state so they change together with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fault_code  <= FAULT_CUP;
            r_start_ready <= 1'b1;
            r_heater_on   <= 1'b0;
            r_pump_on     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_fault_code  <= w_fault_code;
            r_start_ready <= (w_next == ST_IDLE);
            r_heater_on   <= (w_next == ST_HEAT) || (w_next == ST_BREW);
            r_pump_on     <= (w_next == ST_BREW);
            r_busy        <= (w_next == ST_HEAT) || (w_next == ST_BREW) || (w_next == ST_DRIP);
            r_done        <= (w_next == ST_DONE);
            r_fault       <= (w_next == ST_FAULT);
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.heater_on   = r_heater_on;
    assign bus.pump_on     = r_pump_on;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_fault_code;

`ifdef COFFEE_CUP_COUNTER_EN
    logic [15:0] r_cup_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cup_count <= '0;
        end else if ((r_state == ST_DONE) && (r_cup_count != 16'hFFFF)) begin
            r_cup_count <= r_cup_count + 16'd1;
        end
    end

    assign bus.cup_count = r_cup_count;
`endif

endmodule
